ram_simo_pp: RTL and testbench
==============================

RAM_SIMO_PP -- requirements
Module: ram_simo_pp

Interface
REQ-001 Parameter DEPTH, default 64: rows per bank.
REQ-002 Parameter ROW_BITS, default 8: bits per row (power of two).
REQ-003 Parameter OUT_W, default 6: read port width, OUT_W <= ROW_BITS.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 wen  input  1  bit write request.
REQ-007 waddr  input  $clog2(DEPTH*ROW_BITS)  bit address within current write bank.
REQ-008 data_i  input  1  write bit.
REQ-009 wlast  input  1  qualifies an accepted write as the final bit of a symbol; commits the bank.
REQ-010 ren  input  1  row read request.
REQ-011 raddr  input  $clog2(DEPTH)  row address within current read bank.
REQ-012 rlast  input  1  qualifies an accepted read as the final read; releases the bank.
REQ-013 nbits  input  $clog2(OUT_W+1)  valid output bits per read (1..OUT_W; 1/2/4/6 in use).
REQ-014 data_o  output  OUT_W  registered row bits [OUT_W-1:0].
REQ-015 data_o_valid  output  1  data_o holds a fresh read.
REQ-016 w_ready  output  1  a bank is free for writing.
REQ-017 r_ready  output  1  a committed bank is available for reading.
REQ-018 err_ovf  output  1  sticky: write attempted while w_ready=0.
REQ-019 err_udf  output  1  sticky: read attempted while r_ready=0.

Function
REQ-020 Storage: two banks (0,1), each DEPTH*ROW_BITS bits, bit-addressable for writes, row-addressable for reads.
REQ-021 State: wbank (1b), rbank (1b), fill count (0..2).
REQ-022 w_ready = (fill < 2); r_ready = (fill > 0); both combinational from state.
REQ-023 Write accepted when wen && w_ready: bit waddr of bank wbank <= data_i at the next edge.
REQ-024 Accepted write with wlast=1: wbank toggles, fill increments.
REQ-025 wen && !w_ready: no memory change, no state change, err_ovf <= 1.
REQ-026 Read accepted when ren && r_ready: data_o[i] <= bank rbank bit {raddr,i} for i < nbits, else 0; data_o_valid <= 1; latency one cycle.
REQ-027 Cycle without accepted read: data_o_valid <= 0; data_o holds its previous value.
REQ-028 Accepted read with rlast=1: rbank toggles, fill decrements; the rlast read's own data comes from the pre-toggle bank.
REQ-029 ren && !r_ready: data_o_valid <= 0, err_udf <= 1, no state change.
REQ-030 Commit and release in the same cycle: fill unchanged, both pointers toggle.
REQ-031 Commit when fill=1 and no release: fill=2, w_ready falls the next cycle.
REQ-032 Reads and writes always target different banks whenever fill=1; no read-during-write hazard exists, and none is arbitrated.
REQ-033 nbits=0 or nbits>OUT_W: treated as OUT_W.
REQ-034 Out-of-range waddr/raddr (non-power-of-two DEPTH): write ignored; read returns 0 with valid asserted.
REQ-035 Memory contents are not cleared on commit or release; software order guarantees full rewrite.

Reset
REQ-036 rstn low asynchronously forces wbank=0, rbank=0, fill=0, data_o=0, data_o_valid=0, err_ovf=0, err_udf=0; hence w_ready=1, r_ready=0.
REQ-037 Memory contents are not reset; they initialise to zero in simulation only.
REQ-038 Reset asserted mid-symbol discards the partial bank and any committed banks (fill=0); the first accepted write after release of reset targets bank 0.
REQ-039 Sticky errors clear only on reset.

Verification
REQ-040 Fill bank 0 with 48 bits (pattern 0xA5 per row), wlast on the last bit; read rows 0..5 with nbits=6 -> data_o=6'h25 each, valid one cycle after ren; r_ready=1 from the cycle after commit.
REQ-041 Commit two symbols without reads -> w_ready=0; a further wen -> err_ovf=1, bank contents unchanged on readback.
REQ-042 ren at reset exit -> data_o_valid=0, err_udf=1, fill stays 0.
REQ-043 fill=1; commit (wlast) and release (rlast) in the same cycle -> fill=1, wbank=0, rbank=1; next read returns the second symbol's data.
REQ-044 Row bits 6'h3F, nbits=2 -> data_o=6'h03; nbits=0 -> 6'h3F.
REQ-045 Assert rstn low mid-write of the second symbol -> all outputs at reset values immediately (asynchronous), w_ready=1, r_ready=0.

Source files
------------

// File: rtl/ram_simo_pp_if.sv
// Bus bundle for the ping-pong bit-write / row-read buffer.
// The master drives requests; the slave (the buffer) returns data, flow control and errors.
interface ram_simo_pp_if #(
  parameter int DEPTH    = 64,
  parameter int ROW_BITS = 8,
  parameter int OUT_W    = 6
);
  localparam int WA_W = $clog2(DEPTH * ROW_BITS);
  localparam int RA_W = $clog2(DEPTH);
  localparam int NB_W = $clog2(OUT_W + 1);

  logic              wen;
  logic [WA_W-1:0]   waddr;
  logic              data_i;
  logic              wlast;
  logic              ren;
  logic [RA_W-1:0]   raddr;
  logic              rlast;
  logic [NB_W-1:0]   nbits;
  logic [OUT_W-1:0]  data_o;
  logic              data_o_valid;
  logic              w_ready;
  logic              r_ready;
  logic              err_ovf;
  logic              err_udf;

  modport master (
    output wen, waddr, data_i, wlast, ren, raddr, rlast, nbits,
    input  data_o, data_o_valid, w_ready, r_ready, err_ovf, err_udf
  );

  modport slave (
    input  wen, waddr, data_i, wlast, ren, raddr, rlast, nbits,
    output data_o, data_o_valid, w_ready, r_ready, err_ovf, err_udf
  );
endinterface

// File: rtl/ram_simo_pp.sv
// Two-bank ping-pong buffer: bits are written one at a time into the write bank,
// committed with wlast, then read back a row at a time with a per-read bit count.
module ram_simo_pp #(
  parameter int DEPTH    = 64,
  parameter int ROW_BITS = 8,
  parameter int OUT_W    = 6
) (
  input  logic         clk,
  input  logic         rstn,
  ram_simo_pp_if.slave bus
);
  localparam int WA_W  = $clog2(DEPTH * ROW_BITS);
  localparam int RA_W  = $clog2(DEPTH);
  localparam int NB_W  = $clog2(OUT_W + 1);
  localparam int BIT_W = $clog2(ROW_BITS);
  localparam bit FULL_RANGE = ((1 << RA_W) == DEPTH);

  typedef enum logic [1:0] {
    FILL_NONE = 2'd0,
    FILL_ONE  = 2'd1,
    FILL_TWO  = 2'd2
  } fill_t;

  fill_t               fill;
  logic                wbank;
  logic                rbank;
  logic [OUT_W-1:0]    data_q;
  logic                valid_q;
  logic                ovf_q;
  logic                udf_q;

  logic [ROW_BITS-1:0] mem [2][DEPTH];

  logic                w_ready;
  logic                r_ready;
  logic                wr_acc;
  logic                rd_acc;
  logic                commit;
  logic                rel;
  logic                wr_in_range;
  logic                rd_in_range;
  logic                mem_we;
  logic [RA_W-1:0]     wrow;
  logic [BIT_W-1:0]    wbit;
  logic [NB_W-1:0]     nb_eff;
  logic [ROW_BITS-1:0] rd_row;
  logic [OUT_W-1:0]    rd_data;

  assign w_ready = (fill != FILL_TWO);
  assign r_ready = (fill != FILL_NONE);

  assign wr_acc  = bus.wen && w_ready;
  assign rd_acc  = bus.ren && r_ready;
  assign commit  = wr_acc && bus.wlast;
  assign rel     = rd_acc && bus.rlast;

  assign wrow    = bus.waddr[WA_W-1:BIT_W];
  assign wbit    = bus.waddr[BIT_W-1:0];

  // With a power-of-two depth every address decodes to a real row.
  if (FULL_RANGE) begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range = (32'(wrow) < 32'(DEPTH));
    assign rd_in_range = (32'(bus.raddr) < 32'(DEPTH));
  end

  assign mem_we = wr_acc && wr_in_range && rstn;

  always_comb begin
    nb_eff = bus.nbits;
    if ((bus.nbits == '0) || (32'(bus.nbits) > 32'(OUT_W))) begin
      nb_eff = NB_W'(OUT_W);
    end
  end

  always_comb begin
    rd_row = '0;
    if (rd_in_range) begin
      rd_row = mem[rbank][bus.raddr];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < int'(nb_eff)) begin
        rd_data[i] = rd_row[i];
      end
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wbank][wrow][wbit] <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill    <= FILL_NONE;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (bus.wen && !w_ready) begin
        ovf_q <= 1'b1;
      end
      if (bus.ren && !r_ready) begin
        udf_q <= 1'b1;
      end

      valid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= rd_data;
      end

      if (commit) begin
        wbank <= ~wbank;
      end
      if (rel) begin
        rbank <= ~rbank;
      end

      // Simultaneous commit and release leaves the occupancy unchanged.
      unique case ({commit, rel})
        2'b10:   fill <= (fill == FILL_NONE) ? FILL_ONE : FILL_TWO;
        2'b01:   fill <= (fill == FILL_TWO) ? FILL_ONE : FILL_NONE;
        default: fill <= fill;
      endcase
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_o_valid = valid_q;
  assign bus.w_ready      = w_ready;
  assign bus.r_ready      = r_ready;
  assign bus.err_ovf      = ovf_q;
  assign bus.err_udf      = udf_q;

endmodule

// File: tb/tb_ram_simo_pp.sv
// Bench for ram_simo_pp: a bit-array reference of the two banks and occupancy,
// compared every falling edge, plus directed scenarios with literal expectations.
module tb_ram_simo_pp;
  localparam int DEPTH    = 64;
  localparam int ROW_BITS = 8;
  localparam int OUT_W    = 6;
  localparam int WA_W     = $clog2(DEPTH * ROW_BITS);
  localparam int RA_W     = $clog2(DEPTH);
  localparam int NB_W     = $clog2(OUT_W + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  ram_simo_pp_if #(.DEPTH(DEPTH), .ROW_BITS(ROW_BITS), .OUT_W(OUT_W)) bus ();

  ram_simo_pp #(.DEPTH(DEPTH), .ROW_BITS(ROW_BITS), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: each bank is a flat array of bits, occupancy is a plain count.
  bit               m_mem [2][DEPTH*ROW_BITS];
  int               m_fill;
  bit               m_wb;
  bit               m_rb;
  logic [OUT_W-1:0] m_data;
  bit               m_valid;
  bit               m_ovf;
  bit               m_udf;
  bit               m_wacc;
  bit               m_racc;
  int               m_nb;

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH*ROW_BITS; a++) begin
        m_mem[b][a] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_fill  = 0;
      m_wb    = 1'b0;
      m_rb    = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      m_wacc = bus.wen && (m_fill < 2);
      m_racc = bus.ren && (m_fill > 0);
      if (bus.wen && !m_wacc) m_ovf = 1'b1;
      if (bus.ren && !m_racc) m_udf = 1'b1;
      m_valid = m_racc;
      if (m_racc) begin
        m_nb = int'(bus.nbits);
        if (m_nb == 0 || m_nb > OUT_W) m_nb = OUT_W;
        m_data = '0;
        for (int i = 0; i < m_nb; i++) begin
          m_data[i] = m_mem[m_rb][int'(bus.raddr) * ROW_BITS + i];
        end
      end
      if (m_wacc) m_mem[m_wb][int'(bus.waddr)] = bus.data_i;
      if (m_wacc && bus.wlast) begin
        m_wb   = !m_wb;
        m_fill = m_fill + 1;
      end
      if (m_racc && bus.rlast) begin
        m_rb   = !m_rb;
        m_fill = m_fill - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model data_o",       32'(bus.data_o),       32'(m_data));
      checkOutput("model data_o_valid", 32'(bus.data_o_valid), 32'(m_valid));
      checkOutput("model w_ready",      32'(bus.w_ready),      32'(m_fill < 2));
      checkOutput("model r_ready",      32'(bus.r_ready),      32'(m_fill > 0));
      checkOutput("model err_ovf",      32'(bus.err_ovf),      32'(m_ovf));
      checkOutput("model err_udf",      32'(bus.err_udf),      32'(m_udf));
    end
  end

  task automatic setIdle();
    bus.wen    = 1'b0;
    bus.waddr  = '0;
    bus.data_i = 1'b0;
    bus.wlast  = 1'b0;
    bus.ren    = 1'b0;
    bus.raddr  = '0;
    bus.rlast  = 1'b0;
    bus.nbits  = '0;
  endtask

  // One request cycle; returns 2 time units after the edge that consumed it.
  task automatic applyStimulus(input logic wen, input int waddr, input logic din, input logic wlast,
                               input logic ren, input int raddr, input logic rlast, input int nbits);
    bus.wen    = wen;
    bus.waddr  = WA_W'(waddr);
    bus.data_i = din;
    bus.wlast  = wlast;
    bus.ren    = ren;
    bus.raddr  = RA_W'(raddr);
    bus.rlast  = rlast;
    bus.nbits  = NB_W'(nbits);
    @(posedge clk);
    #2;
    setIdle();
  endtask

  task automatic writeSymbol(input logic [7:0] pat, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int b = 0; b < ROW_BITS; b++) begin
        applyStimulus(1'b1, r*ROW_BITS + b, pat[b], (r == nrows-1) && (b == ROW_BITS-1),
                      1'b0, 0, 1'b0, 0);
      end
    end
  endtask

  task automatic readRow(input string name, input int row, input int nb, input logic last,
                         input logic [OUT_W-1:0] exp);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, row, last, nb);
    checkOutput(name, 32'(bus.data_o), 32'(exp));
    checkOutput({name, " valid"}, 32'(bus.data_o_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] pat;
    setIdle();
    #1 rstn = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset w_ready", 32'(bus.w_ready),      32'd1);
    checkOutput("reset r_ready", 32'(bus.r_ready),      32'd0);
    checkOutput("reset valid",   32'(bus.data_o_valid), 32'd0);
    checkOutput("reset data_o",  32'(bus.data_o),       32'd0);
    rstn = 1'b1;

    // Read straight out of reset: underflow, nothing changes.
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 6);
    checkOutput("udf valid",   32'(bus.data_o_valid), 32'd0);
    checkOutput("udf err",     32'(bus.err_udf),      32'd1);
    checkOutput("udf r_ready", 32'(bus.r_ready),      32'd0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    checkOutput("udf sticky",  32'(bus.err_udf),      32'd1);
    rstn = 1'b0;
    #1 checkOutput("udf cleared by reset", 32'(bus.err_udf), 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;

    // 48 bits of 0xA5 rows into bank 0, read back six rows.
    writeSymbol(8'hA5, 6);
    checkOutput("commit r_ready", 32'(bus.r_ready), 32'd1);
    for (int r = 0; r < 6; r++) begin
      readRow($sformatf("A5 row%0d", r), r, 6, r == 5, 6'h25);
    end
    checkOutput("A5 released r_ready", 32'(bus.r_ready), 32'd0);

    // nbits masking on rows of 0x3F.
    writeSymbol(8'h3F, 2);
    readRow("3F nbits2", 0, 2, 1'b0, 6'h03);
    readRow("3F nbits0", 0, 0, 1'b0, 6'h3F);
    readRow("3F nbits4", 1, 4, 1'b0, 6'h0F);
    readRow("3F nbits7", 1, 7, 1'b1, 6'h3F);

    // Two commits fill the buffer; a further write overflows and is dropped.
    writeSymbol(8'h5A, 6);
    writeSymbol(8'h3C, 6);
    checkOutput("full w_ready", 32'(bus.w_ready), 32'd0);
    applyStimulus(1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    checkOutput("ovf err", 32'(bus.err_ovf), 32'd1);
    readRow("5A after ovf", 0, 6, 1'b1, 6'h1A);
    checkOutput("one left w_ready", 32'(bus.w_ready), 32'd1);

    // Commit and release land on the same edge.
    pat = 8'h27;
    for (int a = 0; a < 47; a++) begin
      applyStimulus(1'b1, a, pat[a % 8], 1'b0, 1'b0, 0, 1'b0, 0);
    end
    applyStimulus(1'b1, 47, pat[7], 1'b1, 1'b1, 0, 1'b1, 6);
    checkOutput("swap data",    32'(bus.data_o),  32'h3C);
    checkOutput("swap r_ready", 32'(bus.r_ready), 32'd1);
    checkOutput("swap w_ready", 32'(bus.w_ready), 32'd1);
    readRow("27 after swap", 2, 6, 1'b1, 6'h27);

    // Asynchronous reset in the middle of the second symbol.
    writeSymbol(8'h96, 6);
    readRow("96 row0", 0, 6, 1'b0, 6'h16);
    pat = 8'hFF;
    for (int a = 0; a < 10; a++) begin
      applyStimulus(1'b1, a, pat[a % 8], 1'b0, 1'b0, 0, 1'b0, 0);
    end
    #1 rstn = 1'b0;
    #1;
    checkOutput("async data_o",  32'(bus.data_o),       32'd0);
    checkOutput("async valid",   32'(bus.data_o_valid), 32'd0);
    checkOutput("async w_ready", 32'(bus.w_ready),      32'd1);
    checkOutput("async r_ready", 32'(bus.r_ready),      32'd0);
    checkOutput("async err_ovf", 32'(bus.err_ovf),      32'd0);
    checkOutput("async err_udf", 32'(bus.err_udf),      32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;

    // First symbol after reset lands in bank 0; row 1 still holds earlier 0x27.
    writeSymbol(8'h33, 1);
    readRow("post reset row1", 1, 6, 1'b0, 6'h27);
    readRow("post reset row0", 0, 6, 1'b1, 6'h33);

    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    #2;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
